dbg_av_trace_slave: RTL and testbench

//  Avalon-MM write-only responder for the supervisor's debug master port (dbg_av_*).

---
 rtl/dbg_av_trace_slave.sv | 97 +++++++++
 tb/tb_dbg_av_trace_slave.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dbg_av_trace_slave.sv
// rtl/dbg_av_trace_slave.sv - Avalon-MM write-only debug trace responder
// Buffers accepted {address,data} writes in a FIFO drained over a valid/ready stream.
module dbg_av_trace_slave #(
  parameter int          DEPTH_LOG2  = 4,
  parameter logic [15:0] CTRL_ADDR   = 16'hFFF0,
  parameter int          STALL_LIMIT = 255
) (
  input  logic                  sysclk,
  input  logic                  sysreset,
  input  logic [15:0]           av_address,
  input  logic                  av_write,
  input  logic [15:0]           av_writedata,
  output logic                  av_waitrequest,
  output logic [15:0]           out_addr,
  output logic [15:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [15:0]           drop_count,
  output logic                  overflow
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FILL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] FILL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [15:0]         STALL_MAX = 16'(STALL_LIMIT);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [15:0]           stall_cnt;

  logic full;
  logic timeout;
  logic is_ctrl;
  logic accept;
  logic do_flush;
  logic do_clear;
  logic push;
  logic pop;
  logic drop;

  assign full     = (fill_level == FILL_FULL);
  assign timeout  = (stall_cnt == STALL_MAX);
  assign is_ctrl  = (av_address == CTRL_ADDR);

  // Control writes bypass the FIFO, so they must never be held off by a full queue.
  assign av_waitrequest = av_write && full && !timeout && !is_ctrl;
  assign accept   = av_write && !av_waitrequest;
  assign do_flush = accept && is_ctrl && av_writedata[0];
  assign do_clear = accept && is_ctrl && av_writedata[1];
  assign push     = accept && !is_ctrl && !full;
  assign drop     = accept && !is_ctrl && full;
  assign out_valid = (fill_level != '0);
  assign pop      = out_valid && out_ready && !do_flush;

  assign out_addr = mem[rd_ptr][31:16];
  assign out_data = mem[rd_ptr][15:0];

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= {av_address, av_writedata};
  end

  always_ff @(posedge sysclk) begin
    if (sysreset || do_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fill_level <= fill_level + FILL_ONE;
        2'b01:   fill_level <= fill_level - FILL_ONE;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Stall counter only runs while a write is actually being held off.
  always_ff @(posedge sysclk) begin
    if (sysreset || accept || !av_write) stall_cnt <= '0;
    else if (av_waitrequest)             stall_cnt <= stall_cnt + 16'd1;
  end

  always_ff @(posedge sysclk) begin
    if (sysreset || do_clear) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (drop) begin
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dbg_av_trace_slave.sv
// tb/tb_dbg_av_trace_slave.sv - self-checking bench for dbg_av_trace_slave
// Queue scoreboard models FIFO contents, stall counter and drop statistics.
module tb_dbg_av_trace_slave;

  logic        sysclk = 1'b0;
  logic        sysreset = 1'b1;
  logic [15:0] av_address = '0;
  logic        av_write = 1'b0;
  logic [15:0] av_writedata = '0;
  logic        av_waitrequest;
  logic [15:0] out_addr;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  fill_level;
  logic [15:0] drop_count;
  logic        overflow;

  dbg_av_trace_slave dut (
    .sysclk(sysclk), .sysreset(sysreset),
    .av_address(av_address), .av_write(av_write), .av_writedata(av_writedata),
    .av_waitrequest(av_waitrequest),
    .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fill_level(fill_level), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 sysclk = ~sysclk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sb[$];
  int          stall_m = 0;
  logic [15:0] drop_m = '0;
  logic        ovf_m = 1'b0;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic        rdy;
    logic        exp_wait;
    int          exp_fill;
    logic        exp_valid;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; applies inputs, checks against the model, advances one cycle.
  task automatic cycle(input logic rst, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input logic rdy);
    logic full_m, wait_m, ctrl, acc, flush, clr, pop, push, drop;
    sysreset = rst; av_write = wr; av_address = a; av_writedata = d; out_ready = rdy;
    #1;
    full_m = (sb.size() == 16);
    ctrl   = (a == 16'hFFF0);
    wait_m = wr && full_m && (stall_m != 255) && !ctrl;
    chk("waitrequest", {31'd0, av_waitrequest}, {31'd0, wait_m});
    chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    chk("fill_level", {27'd0, fill_level}, sb.size());
    chk("drop_count", {16'd0, drop_count}, {16'd0, drop_m});
    chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
    if (sb.size() != 0) chk("head", {out_addr, out_data}, sb[0]);
    if (rst) begin
      sb.delete(); stall_m = 0; drop_m = '0; ovf_m = 1'b0;
    end else begin
      acc   = wr && !wait_m;
      flush = acc && ctrl && d[0];
      clr   = acc && ctrl && d[1];
      pop   = (sb.size() != 0) && rdy && !flush;
      push  = acc && !ctrl && !full_m;
      drop  = acc && !ctrl && full_m;
      if (pop) void'(sb.pop_front());
      if (flush) sb.delete();
      if (push) sb.push_back({a, d});
      if (acc || !wr) stall_m = 0; else stall_m++;
      if (clr) begin drop_m = '0; ovf_m = 1'b0; end
      if (drop) begin
        if (drop_m != 16'hFFFF) drop_m++;
        ovf_m = 1'b1;
      end
    end
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, rdy);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{rst:1, wr:0, addr:16'h0000, data:16'h0000, rdy:0, exp_wait:0, exp_fill:0, exp_valid:0};
    tbl[1] = '{rst:0, wr:1, addr:16'h0010, data:16'hABCD, rdy:0, exp_wait:0, exp_fill:1, exp_valid:1};
    tbl[2] = '{rst:0, wr:0, addr:16'h0000, data:16'h0000, rdy:0, exp_wait:0, exp_fill:1, exp_valid:1};
    tbl[3] = '{rst:0, wr:1, addr:16'h0020, data:16'h1234, rdy:1, exp_wait:0, exp_fill:1, exp_valid:1};
    tbl[4] = '{rst:0, wr:0, addr:16'h0000, data:16'h0000, rdy:1, exp_wait:0, exp_fill:0, exp_valid:0};
    tbl[5] = '{rst:0, wr:1, addr:16'h0030, data:16'h5555, rdy:1, exp_wait:0, exp_fill:1, exp_valid:1};
    tbl[6] = '{rst:0, wr:1, addr:16'h0040, data:16'h6666, rdy:1, exp_wait:0, exp_fill:1, exp_valid:1};
    tbl[7] = '{rst:0, wr:0, addr:16'h0000, data:16'h0000, rdy:1, exp_wait:0, exp_fill:0, exp_valid:0};

    @(posedge sysclk);
    @(negedge sysclk);
    sysreset = 1'b0;
    #1;
    chk("reset fill_level", {27'd0, fill_level}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset drop_count", {16'd0, drop_count}, 32'd0);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    @(negedge sysclk);

    // Single write visibility, push+pop, empty push-only
    for (int i = 0; i < 8; i++) begin
      sysreset = tbl[i].rst; av_write = tbl[i].wr; av_address = tbl[i].addr;
      av_writedata = tbl[i].data; out_ready = tbl[i].rdy;
      #1;
      chk("tbl wait", {31'd0, av_waitrequest}, {31'd0, tbl[i].exp_wait});
      #1;
      cycle(tbl[i].rst, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].rdy);
      chk("tbl fill", {27'd0, fill_level}, tbl[i].exp_fill);
      chk("tbl valid", {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
      if (i == 1) chk("tbl first entry", {out_addr, out_data}, 32'h0010ABCD);
    end

    // Fill to 16, stalled 17th write, single pop lets it through next cycle
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 16'(i), 16'(i), 1'b0);
    chk("full fill", {27'd0, fill_level}, 32'd16);
    av_write = 1'b1; av_address = 16'h0100; av_writedata = 16'h00FF;
    #1;
    chk("17th stalls", {31'd0, av_waitrequest}, 32'd1);
    cycle(1'b0, 1'b1, 16'h0100, 16'h00FF, 1'b0);
    cycle(1'b0, 1'b1, 16'h0100, 16'h00FF, 1'b1);
    chk("after pop fill", {27'd0, fill_level}, 32'd15);
    cycle(1'b0, 1'b1, 16'h0100, 16'h00FF, 1'b0);
    chk("17th accepted", {27'd0, fill_level}, 32'd16);
    for (int i = 1; i < 16; i++) begin
      chk("drain order", {16'd0, out_data}, i);
      idle(1'b1);
    end
    chk("drain last", {out_addr, out_data}, 32'h010000FF);
    idle(1'b1);
    chk("drained empty", {31'd0, out_valid}, 32'd0);

    // Stall timeout drops, five times
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 16'h0200 + 16'(i), 16'($urandom), 1'b0);
    for (int k = 1; k <= 5; k++) begin
      for (int c = 0; c < 256; c++) begin
        if (k == 1 && c == 255) begin
          #1;
          chk("wait before timeout", {31'd0, av_waitrequest}, 32'd0);
        end
        cycle(1'b0, 1'b1, 16'h0300, 16'hDEAD, 1'b0);
      end
      chk("drop_count", {16'd0, drop_count}, k);
    end
    idle(1'b0);
    chk("overflow set", {31'd0, overflow}, 32'd1);
    chk("fill after drops", {27'd0, fill_level}, 32'd16);

    // Control write with full FIFO: flush and clear
    av_write = 1'b1; av_address = 16'hFFF0; av_writedata = 16'h0003;
    #1;
    chk("ctrl no stall", {31'd0, av_waitrequest}, 32'd0);
    cycle(1'b0, 1'b1, 16'hFFF0, 16'h0003, 1'b0);
    chk("ctrl fill", {27'd0, fill_level}, 32'd0);
    chk("ctrl valid", {31'd0, out_valid}, 32'd0);
    chk("ctrl drops", {16'd0, drop_count}, 32'd0);
    chk("ctrl overflow", {31'd0, overflow}, 32'd0);

    // Half full, continuous push+pop with pointer wrap
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 16'h0400 + 16'(i), 16'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 16'h0500 + 16'(i), 16'($urandom), 1'b1);
    chk("steady fill", {27'd0, fill_level}, 32'd8);

    // Reset with 7 entries queued
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 16'h0600 + 16'(i), 16'(i), 1'b0);
    cycle(1'b1, 1'b1, 16'h0700, 16'h0007, 1'b0);
    chk("rst7 fill", {27'd0, fill_level}, 32'd0);
    chk("rst7 valid", {31'd0, out_valid}, 32'd0);

    // Reset with full FIFO, a drop recorded and a stalled write pending
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 16'h0800 + 16'(i), 16'(i), 1'b0);
    for (int c = 0; c < 256; c++) cycle(1'b0, 1'b1, 16'h0900, 16'hBEEF, 1'b0);
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b1, 16'h0900, 16'hBEEF, 1'b0);
    chk("pre-reset drop", {16'd0, drop_count}, 32'd1);
    cycle(1'b1, 1'b1, 16'h0900, 16'hBEEF, 1'b0);
    av_write = 1'b1; av_address = 16'h0900; av_writedata = 16'hBEEF;
    #1;
    chk("rst wait", {31'd0, av_waitrequest}, 32'd0);
    chk("rst fill", {27'd0, fill_level}, 32'd0);
    chk("rst valid", {31'd0, out_valid}, 32'd0);
    chk("rst drops", {16'd0, drop_count}, 32'd0);
    chk("rst overflow", {31'd0, overflow}, 32'd0);
    #1;
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
